oam_dma: RTL and testbench

- Memory-side initiator: block-copy engine that drives the write/read port of the team's memory model, as the Game Boy OAM DMA does.
- On a start strobe it copies LENGTH bytes from {src_page, 8'h00} upward to DST_BASE upward, one byte per CYCLES_PER_BYTE clocks.
- Sits between the CPU's DMA register write (start/src_page) and the memory read/write port (read_addr/read_data/wen/write_addr/write_data).

---
 rtl/oam_dma_if.sv | 25 ++
 rtl/oam_dma.sv | 76 +++++++
 tb/tb_oam_dma.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_if.sv
// Memory read/write port between the OAM DMA engine and the memory it copies through.
// Read data is combinational for the address presented in the same cycle.
interface oam_dma_if;
  logic [15:0] mem_read_addr;
  logic [7:0]  mem_read_data;
  logic        mem_wen;
  logic [15:0] mem_write_addr;
  logic [7:0]  mem_write_data;

  modport master (
    output mem_read_addr,
    input  mem_read_data,
    output mem_wen,
    output mem_write_addr,
    output mem_write_data
  );

  modport slave (
    input  mem_read_addr,
    output mem_read_data,
    input  mem_wen,
    input  mem_write_addr,
    input  mem_write_data
  );
endinterface

// File: rtl/oam_dma.sv
// Game Boy style OAM DMA: copies LENGTH bytes from {src_page, 8'h00} to DST_BASE,
// one byte every CYCLES_PER_BYTE clocks, restartable by a new start strobe.
module oam_dma #(
  parameter int          LENGTH          = 160,
  parameter logic [15:0] DST_BASE        = 16'hFE00,
  parameter int          CYCLES_PER_BYTE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] src_page,
  output logic       busy,
  output logic       done,
  oam_dma_if.master  mem
);

  localparam int             PW         = (CYCLES_PER_BYTE > 2) ? $clog2(CYCLES_PER_BYTE) : 1;
  localparam logic [PW-1:0]  LAST_PHASE = PW'(CYCLES_PER_BYTE - 1);
  localparam logic [7:0]     LAST_IDX   = 8'(LENGTH - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  logic [0:0]    state;
  logic [7:0]    page;
  logic [7:0]    idx;
  logic [PW-1:0] phase;
  logic [7:0]    latch;
  logic          write_phase;

  // Outputs decode directly from state so an asynchronous reset clears them at once.
  assign busy        = (state == XFER);
  assign write_phase = busy && (phase == LAST_PHASE);

  assign mem.mem_read_addr  = busy ? {page, idx} : 16'h0000;
  assign mem.mem_wen        = write_phase;
  assign mem.mem_write_addr = write_phase ? (DST_BASE + {8'h00, idx}) : 16'h0000;
  assign mem.mem_write_data = write_phase ? latch : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      page  <= 8'h00;
      idx   <= 8'h00;
      phase <= '0;
      latch <= 8'h00;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        // A start always wins, including over the final write cycle: no done pulse.
        state <= XFER;
        page  <= src_page;
        idx   <= 8'h00;
        phase <= '0;
      end else if (state == XFER) begin
        if (phase == '0) begin
          latch <= mem.mem_read_data;
        end
        if (phase == LAST_PHASE) begin
          phase <= '0;
          if (idx == LAST_IDX) begin
            state <= IDLE;
            idx   <= 8'h00;
            done  <= 1'b1;
          end else begin
            idx <= idx + 8'h01;
          end
        end else begin
          phase <= phase + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: a default instance (160 bytes, 4 clk/byte) and a boundary
// instance (256 bytes, 2 clk/byte, destination wrapping past FFFF).
module tb_oam_dma;

  logic       clk;
  logic       rst0_n, rst1_n;
  logic       start0, start1;
  logic [7:0] page0, page1;
  logic       busy0, done0, busy1, done1;
  logic       clr0;

  oam_dma_if bus0 ();
  oam_dma_if bus1 ();

  oam_dma dut0 (
    .clk(clk), .rst_n(rst0_n), .start(start0), .src_page(page0),
    .busy(busy0), .done(done0), .mem(bus0.master)
  );

  oam_dma #(.LENGTH(256), .DST_BASE(16'hFFF0), .CYCLES_PER_BYTE(2)) dut1 (
    .clk(clk), .rst_n(rst1_n), .start(start1), .src_page(page1),
    .busy(busy1), .done(done1), .mem(bus1.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source side is a ROM whose contents depend on the address; for page C0 it is low byte ^ 5A.
  function automatic logic [7:0] src_byte(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ a[15:8] ^ 8'hC0;
  endfunction

  assign bus0.mem_read_data = src_byte(bus0.mem_read_addr);
  assign bus1.mem_read_data = src_byte(bus1.mem_read_addr);

  logic [7:0] dmem0    [65536];
  bit         written0 [65536];

  always @(posedge clk) begin
    if (clr0) begin
      for (int i = 0; i < 65536; i++) written0[i] <= 1'b0;
    end else if (bus0.mem_wen) begin
      dmem0[bus0.mem_write_addr]    <= bus0.mem_write_data;
      written0[bus0.mem_write_addr] <= 1'b1;
    end
  end

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t q0[$];
  wr_t q1[$];

  typedef struct {
    int          k;
    logic        busy;
    logic        done;
    logic        wen;
    logic [15:0] raddr;
    logic [15:0] waddr;
    logic [7:0]  wdata;
  } vec_t;

  vec_t vt[11];

  int checks, failures;
  int busy_cnt0, done_cnt0, busy_cnt1, done_cnt1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic push0(input logic [7:0] pg, input int n);
    for (int i = 0; i < n; i++)
      q0.push_back({16'hFE00 + 16'(i), src_byte({pg, 8'(i)})});
  endtask

  task automatic push1(input logic [7:0] pg, input int n);
    for (int i = 0; i < n; i++)
      q1.push_back({16'hFFF0 + 16'(i), src_byte({pg, 8'(i)})});
  endtask

  task automatic mon0();
    wr_t e;
    forever begin
      @(negedge clk);
      if (bus0.mem_wen) begin
        if (q0.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wr0_unexpected actual=%h:%h required=none", bus0.mem_write_addr, bus0.mem_write_data);
        end else begin
          e = q0.pop_front();
          chk("wr0_addr", 64'(bus0.mem_write_addr), 64'(e.a));
          chk("wr0_data", 64'(bus0.mem_write_data), 64'(e.d));
        end
      end
      if (busy0) busy_cnt0++;
      if (done0) done_cnt0++;
    end
  endtask

  task automatic mon1();
    wr_t e;
    forever begin
      @(negedge clk);
      if (bus1.mem_wen) begin
        if (q1.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wr1_unexpected actual=%h:%h required=none", bus1.mem_write_addr, bus1.mem_write_data);
        end else begin
          e = q1.pop_front();
          chk("wr1_addr", 64'(bus1.mem_write_addr), 64'(e.a));
          chk("wr1_data", 64'(bus1.mem_write_data), 64'(e.d));
        end
      end
      if (busy1) busy_cnt1++;
      if (done1) done_cnt1++;
    end
  endtask

  function automatic logic [63:0] outs0();
    return 64'({busy0, done0, bus0.mem_wen, bus0.mem_read_addr, bus0.mem_write_addr, bus0.mem_write_data});
  endfunction

  task automatic clear_mem0();
    @(negedge clk) clr0 = 1'b1;
    @(negedge clk) clr0 = 1'b0;
  endtask

  task automatic mem_check0(input string nm, input logic [7:0] pg, input int nwritten);
    int errs;
    errs = 0;
    for (int i = 0; i < 160; i++) begin
      if (i < nwritten) begin
        if (!written0[16'hFE00 + 16'(i)] || dmem0[16'hFE00 + 16'(i)] !== src_byte({pg, 8'(i)})) errs++;
      end else if (written0[16'hFE00 + 16'(i)]) begin
        errs++;
      end
    end
    chk(nm, 64'(errs), 64'd0);
  endtask

  initial begin
    int vi;
    vt[0]  = '{1,   1'b1, 1'b0, 1'b0, 16'hC000, 16'h0000, 8'h00};
    vt[1]  = '{2,   1'b1, 1'b0, 1'b0, 16'hC000, 16'h0000, 8'h00};
    vt[2]  = '{3,   1'b1, 1'b0, 1'b0, 16'hC000, 16'h0000, 8'h00};
    vt[3]  = '{4,   1'b1, 1'b0, 1'b1, 16'hC000, 16'hFE00, 8'h5A};
    vt[4]  = '{5,   1'b1, 1'b0, 1'b0, 16'hC001, 16'h0000, 8'h00};
    vt[5]  = '{6,   1'b1, 1'b0, 1'b0, 16'hC001, 16'h0000, 8'h00};
    vt[6]  = '{8,   1'b1, 1'b0, 1'b1, 16'hC001, 16'hFE01, 8'h5B};
    vt[7]  = '{9,   1'b1, 1'b0, 1'b0, 16'hC002, 16'h0000, 8'h00};
    vt[8]  = '{640, 1'b1, 1'b0, 1'b1, 16'hC09F, 16'hFE9F, 8'hC5};
    vt[9]  = '{641, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 8'h00};
    vt[10] = '{642, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 8'h00};

    checks = 0; failures = 0;
    busy_cnt0 = 0; done_cnt0 = 0; busy_cnt1 = 0; done_cnt1 = 0;
    rst0_n = 1'b0; rst1_n = 1'b0;
    start0 = 1'b0; start1 = 1'b0; page0 = 8'h00; page1 = 8'h00;
    clr0 = 1'b1;
    fork
      mon0();
      mon1();
    join_none

    // Reset state, with a start strobe that must be ignored while in reset.
    repeat (3) @(negedge clk);
    start0 = 1'b1; page0 = 8'hC0;
    @(negedge clk) start0 = 1'b0;
    chk("reset_outs", outs0(), 64'd0);
    rst0_n = 1'b1; rst1_n = 1'b1; clr0 = 1'b0;
    @(negedge clk);
    chk("start_in_reset_ignored", outs0(), 64'd0);

    // Basic copy with cycle-accurate vector table.
    busy_cnt0 = 0; done_cnt0 = 0;
    push0(8'hC0, 160);
    start0 = 1'b1; page0 = 8'hC0;
    @(negedge clk) start0 = 1'b0;
    vi = 0;
    for (int k = 1; k <= 645; k++) begin
      if (vi < 11 && vt[vi].k == k) begin
        chk($sformatf("vec_k%0d", k), outs0(),
            64'({vt[vi].busy, vt[vi].done, vt[vi].wen, vt[vi].raddr, vt[vi].waddr, vt[vi].wdata}));
        vi++;
      end
      @(negedge clk);
    end
    chk("basic_busy_cycles", 64'(busy_cnt0), 64'd640);
    chk("basic_done_pulses", 64'(done_cnt0), 64'd1);
    chk("basic_queue_empty", 64'(q0.size()), 64'd0);
    mem_check0("basic_mem", 8'hC0, 160);

    // Restart at T+50 with a new page.
    clear_mem0();
    busy_cnt0 = 0; done_cnt0 = 0;
    push0(8'h80, 12);
    start0 = 1'b1; page0 = 8'h80;
    @(negedge clk) start0 = 1'b0;
    repeat (49) @(negedge clk);
    push0(8'h90, 160);
    start0 = 1'b1; page0 = 8'h90;
    @(negedge clk) start0 = 1'b0;
    chk("restart_raddr", 64'(bus0.mem_read_addr), 64'h9000);
    repeat (645) @(negedge clk);
    chk("restart_done_pulses", 64'(done_cnt0), 64'd1);
    chk("restart_busy_cycles", 64'(busy_cnt0), 64'd690);
    chk("restart_queue_empty", 64'(q0.size()), 64'd0);
    mem_check0("restart_mem", 8'h90, 160);

    // Asynchronous reset mid-byte, after the write of FE18.
    clear_mem0();
    push0(8'hC0, 25);
    start0 = 1'b1; page0 = 8'hC0;
    @(negedge clk) start0 = 1'b0;
    repeat (100) @(negedge clk);
    chk("pre_reset_busy", 64'(busy0), 64'd1);
    rst0_n = 1'b0;
    #1;
    chk("async_reset_outs", outs0(), 64'd0);
    @(negedge clk) rst0_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_reset_idle", outs0(), 64'd0);
    chk("reset_queue_empty", 64'(q0.size()), 64'd0);
    mem_check0("reset_mem", 8'hC0, 25);

    // Start coinciding with the final write cycle.
    clear_mem0();
    busy_cnt0 = 0; done_cnt0 = 0;
    push0(8'hC0, 160);
    start0 = 1'b1; page0 = 8'hC0;
    @(negedge clk) start0 = 1'b0;
    repeat (639) @(negedge clk);
    chk("final_cycle_wen", 64'({bus0.mem_wen, bus0.mem_write_addr}), 64'({1'b1, 16'hFE9F}));
    push0(8'hA0, 160);
    start0 = 1'b1; page0 = 8'hA0;
    @(negedge clk) start0 = 1'b0;
    chk("final_restart_state", 64'({busy0, done0, bus0.mem_read_addr}), 64'({1'b1, 1'b0, 16'hA000}));
    repeat (645) @(negedge clk);
    chk("final_restart_done_pulses", 64'(done_cnt0), 64'd1);
    chk("final_restart_queue_empty", 64'(q0.size()), 64'd0);
    mem_check0("final_restart_mem", 8'hA0, 160);

    // Boundary instance: 256 bytes, page FF, destination wrapping through 0000.
    busy_cnt1 = 0; done_cnt1 = 0;
    push1(8'hFF, 256);
    start1 = 1'b1; page1 = 8'hFF;
    @(negedge clk) start1 = 1'b0;
    for (int k = 1; k <= 515; k++) begin
      case (k)
        1:   chk("b_k1_raddr", 64'(bus1.mem_read_addr), 64'hFF00);
        2:   chk("b_k2_write", 64'({bus1.mem_wen, bus1.mem_write_addr}), 64'({1'b1, 16'hFFF0}));
        32:  chk("b_k32_write", 64'({bus1.mem_wen, bus1.mem_write_addr}), 64'({1'b1, 16'hFFFF}));
        34:  chk("b_k34_write", 64'({bus1.mem_wen, bus1.mem_write_addr}), 64'({1'b1, 16'h0000}));
        511: chk("b_k511_raddr", 64'({bus1.mem_wen, bus1.mem_read_addr}), 64'({1'b0, 16'hFFFF}));
        512: chk("b_k512_write", 64'({bus1.mem_wen, bus1.mem_read_addr, bus1.mem_write_addr}),
                 64'({1'b1, 16'hFFFF, 16'h00EF}));
        513: chk("b_k513_done", 64'({busy1, done1, bus1.mem_read_addr}), 64'({1'b0, 1'b1, 16'h0000}));
        default: ;
      endcase
      @(negedge clk);
    end
    chk("b_busy_cycles", 64'(busy_cnt1), 64'd512);
    chk("b_done_pulses", 64'(done_cnt1), 64'd1);
    chk("b_queue_empty", 64'(q1.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
